// File: rtl/fpgaminer_pkg.sv
// fpgaminer_pkg -- shared constants and types for the nonce reporting path.
//   NONCE_WIDTH : width of a golden nonce
//   EMPTY_NONCE : value returned to the host when no nonce is available
//   nonce_t     : nonce word type used by the queue and the comm blocks
package fpgaminer_pkg;

   localparam int NONCE_WIDTH = 32;
   localparam logic [NONCE_WIDTH-1:0] EMPTY_NONCE = 32'hFFFF_FFFF;

   typedef logic [NONCE_WIDTH-1:0] nonce_t;

endpackage

// File: rtl/nonce_queue_ram.sv
// nonce_queue_ram -- simple dual-port storage for the nonce queue.
//   hash_clk : clock
//   wr_en    : write wr_data at wr_addr
//   rd_en    : load rd_data from rd_addr (registered read, 1-cycle latency)
//   rd_data  : holds its value while rd_en is low
// A read and a write to the same address in one cycle return the old word,
// which the full-queue simultaneous push/pop case relies on.
module nonce_queue_ram
   import fpgaminer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          hash_clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  nonce_t        wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output nonce_t        rd_data
);

   nonce_t mem [DEPTH];

   always_ff @(posedge hash_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/nonce_report_queue.sv
// nonce_report_queue -- FIFO of golden nonces awaiting collection by the host.
//   hash_clk, reset      : clock, synchronous active-high reset
//   rx_new_nonce         : pulse, rx_golden_nonce valid this cycle
//   rx_golden_nonce      : nonce to enqueue
//   flush                : drop all entries (new work arrived)
//   rd_en                : host read request
//   rd_data, rd_valid    : read result one cycle after rd_en; EMPTY_NONCE
//                          when nothing was available
//   count, empty, full   : registered occupancy
//   overflow_count       : saturating count of nonces dropped while full
module nonce_report_queue
   import fpgaminer_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int OVF_WIDTH = 16
) (
   input  logic                     hash_clk,
   input  logic                     reset,
   input  logic                     rx_new_nonce,
   input  logic [NONCE_WIDTH-1:0]   rx_golden_nonce,
   input  logic                     flush,
   input  logic                     rd_en,
   output logic [NONCE_WIDTH-1:0]   rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic [OVF_WIDTH-1:0]     overflow_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] head, tail;
   logic [CW-1:0] count_nxt;
   logic          do_pop, do_push, do_drop;
   logic          empty_sel;  // last read found nothing: present EMPTY_NONCE
   nonce_t        ram_q;

   // flush wins over both a pop and a push in the same cycle.
   assign do_pop  = rd_en && !empty && !flush;
   // A pop frees the slot the push needs, so a full queue still accepts.
   assign do_push = rx_new_nonce && !flush && (!full || do_pop);
   assign do_drop = rx_new_nonce && !flush && full && !do_pop;

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (do_push && !do_pop)
         count_nxt = count + CW'(1);
      else if (do_pop && !do_push)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         empty          <= 1'b1;
         full           <= 1'b0;
         overflow_count <= '0;
         rd_valid       <= 1'b0;
         empty_sel      <= 1'b1;
      end else begin
         rd_valid <= rd_en;
         // Only updated on a read so rd_data holds between reads.
         if (rd_en) empty_sel <= !do_pop;
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CW'(DEPTH));
         if (flush) begin
            head <= tail;
         end else begin
            if (do_pop)  head <= head + AW'(1);
            if (do_push) tail <= tail + AW'(1);
         end
         if (do_drop && !(&overflow_count))
            overflow_count <= overflow_count + OVF_WIDTH'(1);
      end
   end

   nonce_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .hash_clk (hash_clk),
      .wr_en    (do_push),
      .wr_addr  (tail),
      .wr_data  (rx_golden_nonce),
      .rd_en    (do_pop),
      .rd_addr  (head),
      .rd_data  (ram_q)
   );

   assign rd_data = empty_sel ? EMPTY_NONCE : ram_q;

endmodule
